// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg -- shared definitions for the front panel scanner.
//   FP_NSLOTS         : number of front panel sources scanned per frame
//   FP_SETTLE_DEFAULT : default number of extra strobe-low cycles before sampling
//   fp_slot_e         : slot enumeration, also the scan order
//   fp_state_e        : scanner FSM states
//   fp_strobe_mask()  : active-low strobe vector with only the given slot low
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int FP_NSLOTS         = 7;
   localparam int FP_SETTLE_DEFAULT = 2;

   typedef enum logic [2:0] {
      FP_UA0   = 3'd0,
      FP_UC0   = 3'd1,
      FP_UC1   = 3'd2,
      FP_UC2   = 3'd3,
      FP_IRL   = 3'd4,
      FP_IRH   = 3'd5,
      FP_FLAGS = 3'd6
   } fp_slot_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_SETTLE,
      ST_GAP
   } fp_state_e;

   function automatic logic [FP_NSLOTS-1:0] fp_strobe_mask(input fp_slot_e slot);
      logic [FP_NSLOTS-1:0] one;
      one = 1;
      return ~(one << slot);
   endfunction

endpackage

// File: rtl/fp_settle_timer.sv
// -----------------------------------------------------------------------------
// fp_settle_timer -- down-counter timing the settle phase of a strobe.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   load_i     : load load_val_i into the counter
//   count_i    : decrement the counter (stops at zero)
//   load_val_i : number of settle cycles to time
//   expire_o   : high during the last settle cycle (counter == 1)
// -----------------------------------------------------------------------------
module fp_settle_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic       count_i,
   input  logic [3:0] load_val_i,
   output logic       expire_o
);

   logic [3:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (count_i && (cnt_q != 4'd0)) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Counter value 1 marks the final settle cycle; the scanner samples on the
   // edge that ends it.
   assign expire_o = (cnt_q == 4'd1);

endmodule

// File: rtl/fp_scanner.sv
// -----------------------------------------------------------------------------
// fp_scanner -- scans seven front panel sources through active-low strobes,
// capturing each byte into a working bank and committing the whole frame
// atomically to a committed bank readable through rd_sel/rd_data.
//   clk, reset          : system clock, asynchronous active-high reset
//   enable              : continuous scan request
//   snap                : single-frame request (level, sampled in IDLE)
//   fpd                 : front panel data, valid while a strobe is low
//   nfpua0..nfpflags    : active-low per-source read strobes (registered)
//   rd_sel, rd_data     : committed-bank byte select / byte (8'h00 for sel 7)
//   busy                : frame in progress
//   frame_done          : one-cycle pulse after the commit edge
//   changed             : per-slot change mask of the last commit
// Build option: define FP_SCAN_CHANGE_EN to build the change-detect logic;
// otherwise changed is tied to 7'h00.
// -----------------------------------------------------------------------------
module fp_scanner
   import fp_pkg::*;
#(
   parameter int SETTLE_CYCLES = FP_SETTLE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       snap,
   input  logic [7:0] fpd,
   output logic       nfpua0,
   output logic       nfpuc0,
   output logic       nfpuc1,
   output logic       nfpuc2,
   output logic       nfpirl,
   output logic       nfpirh,
   output logic       nfpflags,
   input  logic [2:0] rd_sel,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       frame_done,
   output logic [6:0] changed
);

   localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

   fp_state_e            state_q;
   fp_slot_e             slot_q;
   fp_slot_e             next_slot;
   logic [FP_NSLOTS-1:0] strobe_n_q;
   logic                 busy_q;
   logic                 frame_done_q;
   logic [7:0]           working_q   [FP_NSLOTS];
   logic [7:0]           committed_q [FP_NSLOTS];
   logic [7:0]           new_bank    [FP_NSLOTS];
   logic                 timer_expire;
   logic                 sample_now;
   logic                 commit;

   fp_settle_timer u_settle_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (state_q == ST_STROBE),
      .count_i    (state_q == ST_SETTLE),
      .load_val_i (4'(SETTLE_CYCLES)),
      .expire_o   (timer_expire)
   );

   // Sampling edge ends the last strobe-low cycle: the STROBE cycle itself
   // when there is no settle phase, otherwise the final SETTLE cycle.
   assign sample_now = ((state_q == ST_STROBE) && NO_SETTLE) ||
                       ((state_q == ST_SETTLE) && timer_expire);
   assign commit     = sample_now && (slot_q == FP_FLAGS);
   assign next_slot  = fp_slot_e'(slot_q + 3'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         slot_q       <= FP_UA0;
         strobe_n_q   <= '1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= commit;
         case (state_q)
            ST_IDLE: begin
               if (enable || snap) begin
                  state_q    <= ST_STROBE;
                  slot_q     <= FP_UA0;
                  strobe_n_q <= fp_strobe_mask(FP_UA0);
                  busy_q     <= 1'b1;
               end
            end
            ST_STROBE: begin
               if (sample_now) begin
                  state_q    <= ST_GAP;
                  strobe_n_q <= '1;
               end else begin
                  state_q    <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (sample_now) begin
                  state_q    <= ST_GAP;
                  strobe_n_q <= '1;
               end
            end
            ST_GAP: begin
               if (slot_q == FP_FLAGS) begin
                  slot_q <= FP_UA0;
                  // enable is only looked at here, so a frame always completes.
                  if (enable) begin
                     state_q    <= ST_STROBE;
                     strobe_n_q <= fp_strobe_mask(FP_UA0);
                  end else begin
                     state_q    <= ST_IDLE;
                     busy_q     <= 1'b0;
                  end
               end else begin
                  state_q    <= ST_STROBE;
                  slot_q     <= next_slot;
                  strobe_n_q <= fp_strobe_mask(next_slot);
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               strobe_n_q <= '1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   // The committed image is the working bank with the slot-6 byte taken
   // straight from the bus, since it is captured on the commit edge itself.
   always_comb begin
      new_bank                = working_q;
      new_bank[FP_NSLOTS - 1] = fpd;
   end

   // NOTE: both banks are small register arrays that must read 8'h00 after
   // reset, so they are cleared explicitly rather than left uninitialised.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FP_NSLOTS; i++) begin
            working_q[i]   <= 8'h00;
            committed_q[i] <= 8'h00;
         end
      end else if (sample_now) begin
         working_q[slot_q] <= fpd;
         if (commit) begin
            committed_q <= new_bank;
         end
      end
   end

`ifdef FP_SCAN_CHANGE_EN
   logic [FP_NSLOTS-1:0] diff;
   logic [FP_NSLOTS-1:0] changed_q;

   always_comb begin
      diff = '0;
      for (int i = 0; i < FP_NSLOTS; i++) begin
         diff[i] = (new_bank[i] != committed_q[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         changed_q <= '0;
      end else if (commit) begin
         changed_q <= diff;
      end
   end

   assign changed = changed_q;
`else
   assign changed = 7'h00;
`endif

   always_comb begin
      rd_data = 8'h00;
      if (rd_sel < 3'(FP_NSLOTS)) begin
         rd_data = committed_q[rd_sel];
      end
   end

   assign nfpua0     = strobe_n_q[FP_UA0];
   assign nfpuc0     = strobe_n_q[FP_UC0];
   assign nfpuc1     = strobe_n_q[FP_UC1];
   assign nfpuc2     = strobe_n_q[FP_UC2];
   assign nfpirl     = strobe_n_q[FP_IRL];
   assign nfpirh     = strobe_n_q[FP_IRH];
   assign nfpflags   = strobe_n_q[FP_FLAGS];
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fp_scanner.sv
// -----------------------------------------------------------------------------
// tb_fp_scanner -- directed bench for fp_scanner. Instance dut uses the default
// settle (2), instance dut_z uses SETTLE_CYCLES=0. A CTL card model drives fpd
// from a per-slot table while the matching strobe is low. Cycle t=1 is the
// first cycle with slot 0 strobe low; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fp_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   always #5 clk = ~clk;

   // default-settle instance
   logic       enable, snap;
   logic [7:0] fpd;
   logic       nfpua0, nfpuc0, nfpuc1, nfpuc2, nfpirl, nfpirh, nfpflags;
   logic [2:0] rd_sel;
   logic [7:0] rd_data;
   logic       busy, frame_done;
   logic [6:0] changed;
   logic [6:0] st;
   logic [7:0] ctl [7];

   // zero-settle instance
   logic       enable_z, snap_z;
   logic [7:0] fpd_z;
   logic       nfpua0_z, nfpuc0_z, nfpuc1_z, nfpuc2_z, nfpirl_z, nfpirh_z, nfpflags_z;
   logic [2:0] rd_sel_z;
   logic [7:0] rd_data_z;
   logic       busy_z, frame_done_z;
   logic [6:0] changed_z;
   logic [6:0] st_z;
   logic [7:0] ctl_z [7];

   int n_tests = 0;
   int n_fail  = 0;

   fp_scanner dut (
      .clk(clk), .reset(reset), .enable(enable), .snap(snap), .fpd(fpd),
      .nfpua0(nfpua0), .nfpuc0(nfpuc0), .nfpuc1(nfpuc1), .nfpuc2(nfpuc2),
      .nfpirl(nfpirl), .nfpirh(nfpirh), .nfpflags(nfpflags),
      .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy),
      .frame_done(frame_done), .changed(changed)
   );

   fp_scanner #(.SETTLE_CYCLES(0)) dut_z (
      .clk(clk), .reset(reset), .enable(enable_z), .snap(snap_z), .fpd(fpd_z),
      .nfpua0(nfpua0_z), .nfpuc0(nfpuc0_z), .nfpuc1(nfpuc1_z), .nfpuc2(nfpuc2_z),
      .nfpirl(nfpirl_z), .nfpirh(nfpirh_z), .nfpflags(nfpflags_z),
      .rd_sel(rd_sel_z), .rd_data(rd_data_z), .busy(busy_z),
      .frame_done(frame_done_z), .changed(changed_z)
   );

   assign st   = {nfpflags, nfpirh, nfpirl, nfpuc2, nfpuc1, nfpuc0, nfpua0};
   assign st_z = {nfpflags_z, nfpirh_z, nfpirl_z, nfpuc2_z, nfpuc1_z, nfpuc0_z, nfpua0_z};

   // CTL card model: drives the table byte of whichever slot is strobed.
   always_comb begin
      fpd = 8'hEE;
      for (int i = 0; i < 7; i++) if (!st[i]) fpd = ctl[i];
   end
   always_comb begin
      fpd_z = 8'hEE;
      for (int i = 0; i < 7; i++) if (!st_z[i]) fpd_z = ctl_z[i];
   end

   // Expected strobe vector in frame cycle t for a given settle count.
   function automatic logic [6:0] exp_strobe(input int t, input int s);
      int         len;
      logic [6:0] m;
      m   = 7'h7F;
      len = s + 2;
      if (t >= 1 && t <= 7 * len && ((t - 1) % len) <= s) m[(t - 1) / len] = 1'b0;
      return m;
   endfunction

   // Raise snap for one edge; returns at the falling edge of cycle t=1.
   task automatic start_snap();
      snap = 1'b1;
      @(posedge clk);
      @(negedge clk);
      snap = 1'b0;
   endtask

   task automatic test_reset();
      enable = 0; snap = 0; enable_z = 0; snap_z = 0; rd_sel = 0; rd_sel_z = 0;
      for (int i = 0; i < 7; i++) begin ctl[i] = 8'h00; ctl_z[i] = 8'h00; end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++; if (st !== 7'h7F) begin n_fail++; $display("FAIL reset_strobes got %b exp 1111111", st); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
      n_tests++; if (changed !== 7'h00) begin n_fail++; $display("FAIL reset_changed got %b exp 0000000", changed); end
      n_tests++; if (st_z !== 7'h7F) begin n_fail++; $display("FAIL reset_strobes_z got %b exp 1111111", st_z); end
      n_tests++; if (busy_z !== 1'b0) begin n_fail++; $display("FAIL reset_busy_z got %b exp 0", busy_z); end
      for (int i = 0; i < 8; i++) begin
         rd_sel = 3'(i); #1;
         n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd sel=%0d got %h exp 00", i, rd_data); end
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (st !== 7'h7F || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got st=%b busy=%b exp 1111111/0", st, busy); end
   endtask

   task automatic test_snap_frame();
      logic [7:0] e;
      for (int i = 0; i < 7; i++) ctl[i] = 8'(8'h10 + i);
      rd_sel = 3'd3;
      start_snap();
      for (int t = 1; t <= 30; t++) begin
         n_tests++; if (st !== exp_strobe(t, 2)) begin n_fail++; $display("FAIL snap_strobes t=%0d got %b exp %b", t, st, exp_strobe(t, 2)); end
         n_tests++; if (busy !== (t <= 28)) begin n_fail++; $display("FAIL snap_busy t=%0d got %b exp %b", t, busy, (t <= 28)); end
         n_tests++; if (frame_done !== (t == 28)) begin n_fail++; $display("FAIL snap_frame_done t=%0d got %b exp %b", t, frame_done, (t == 28)); end
         e = (t >= 28) ? 8'h13 : 8'h00;
         n_tests++; if (rd_data !== e) begin n_fail++; $display("FAIL snap_rd_hold t=%0d got %h exp %h", t, rd_data, e); end
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         rd_sel = 3'(i); #1;
         e = (i < 7) ? 8'(8'h10 + i) : 8'h00;
         n_tests++; if (rd_data !== e) begin n_fail++; $display("FAIL snap_rd sel=%0d got %h exp %h", i, rd_data, e); end
      end
   endtask

   task automatic test_continuous();
      logic [6:0] es;
      for (int i = 0; i < 7; i++) ctl[i] = 8'(8'h20 + i);
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int t = 1; t <= 86; t++) begin
         es = (t <= 84) ? exp_strobe(((t - 1) % 28) + 1, 2) : 7'h7F;
         n_tests++; if (st !== es) begin n_fail++; $display("FAIL cont_strobes t=%0d got %b exp %b", t, st, es); end
         n_tests++; if (busy !== (t <= 84)) begin n_fail++; $display("FAIL cont_busy t=%0d got %b exp %b", t, busy, (t <= 84)); end
         n_tests++; if (frame_done !== (t <= 84 && t % 28 == 0)) begin n_fail++; $display("FAIL cont_frame_done t=%0d got %b", t, frame_done); end
         if (t == 60) enable = 1'b0;
         @(negedge clk);
      end
      for (int i = 0; i < 7; i++) begin
         rd_sel = 3'(i); #1;
         n_tests++; if (rd_data !== 8'(8'h20 + i)) begin n_fail++; $display("FAIL cont_rd sel=%0d got %h exp %h", i, rd_data, 8'(8'h20 + i)); end
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] e;
      for (int i = 0; i < 7; i++) ctl[i] = 8'(8'h30 + i);
      rd_sel = 3'd2;
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int t = 1; t <= 31; t++) begin
         e = (t >= 28) ? 8'h32 : 8'h22;
         n_tests++; if (rd_data !== e) begin n_fail++; $display("FAIL drop_rd_hold t=%0d got %h exp %h", t, rd_data, e); end
         n_tests++; if (st !== exp_strobe(t, 2)) begin n_fail++; $display("FAIL drop_strobes t=%0d got %b exp %b", t, st, exp_strobe(t, 2)); end
         n_tests++; if (busy !== (t <= 28)) begin n_fail++; $display("FAIL drop_busy t=%0d got %b exp %b", t, busy, (t <= 28)); end
         n_tests++; if (frame_done !== (t == 28)) begin n_fail++; $display("FAIL drop_frame_done t=%0d got %b exp %b", t, frame_done, (t == 28)); end
         if (t == 5) enable = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 7; i++) ctl[i] = 8'(8'h40 + i);
      start_snap();
      for (int t = 1; t <= 9; t++) @(negedge clk);
      n_tests++; if (st !== exp_strobe(10, 2)) begin n_fail++; $display("FAIL midrst_pre t=10 got %b exp %b", st, exp_strobe(10, 2)); end
      reset = 1'b1;
      #1;
      n_tests++; if (st !== 7'h7F) begin n_fail++; $display("FAIL midrst_strobes got %b exp 1111111", st); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
      for (int i = 0; i < 8; i++) begin
         rd_sel = 3'(i); #1;
         n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rd sel=%0d got %h exp 00", i, rd_data); end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++; if (frame_done !== 1'b0 || st !== 7'h7F) begin n_fail++; $display("FAIL midrst_hold c=%0d got fd=%b st=%b exp 0/1111111", c, frame_done, st); end
      end
      reset = 1'b0;
      repeat (30) @(negedge clk);
      n_tests++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got busy=%b fd=%b exp 0/0", busy, frame_done); end
   endtask

   task automatic test_change();
      logic [6:0] exp1, exp2;
`ifdef FP_SCAN_CHANGE_EN
      exp1 = 7'b0100000;
      exp2 = 7'b0000100;
`else
      exp1 = 7'h00;
      exp2 = 7'h00;
`endif
      for (int i = 0; i < 7; i++) ctl[i] = 8'h00;
      ctl[5] = 8'hAA;
      rd_sel = 3'd5;
      start_snap();
      repeat (29) @(negedge clk);
      n_tests++; if (changed !== exp1) begin n_fail++; $display("FAIL change_f1 got %b exp %b", changed, exp1); end
      n_tests++; if (rd_data !== 8'hAA) begin n_fail++; $display("FAIL change_f1_rd got %h exp aa", rd_data); end
      ctl[2] = 8'h01;
      rd_sel = 3'd2;
      start_snap();
      repeat (9) @(negedge clk);
      n_tests++; if (changed !== exp1) begin n_fail++; $display("FAIL change_held got %b exp %b", changed, exp1); end
      repeat (20) @(negedge clk);
      n_tests++; if (changed !== exp2) begin n_fail++; $display("FAIL change_f2 got %b exp %b", changed, exp2); end
      n_tests++; if (rd_data !== 8'h01) begin n_fail++; $display("FAIL change_f2_rd got %h exp 01", rd_data); end
   endtask

   task automatic test_settle0();
      logic [7:0] e;
      for (int i = 0; i < 7; i++) ctl_z[i] = 8'(8'h50 + i);
      snap_z = 1'b1;
      @(posedge clk);
      @(negedge clk);
      snap_z = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         n_tests++; if (st_z !== exp_strobe(t, 0)) begin n_fail++; $display("FAIL s0_strobes t=%0d got %b exp %b", t, st_z, exp_strobe(t, 0)); end
         n_tests++; if (busy_z !== (t <= 14)) begin n_fail++; $display("FAIL s0_busy t=%0d got %b exp %b", t, busy_z, (t <= 14)); end
         n_tests++; if (frame_done_z !== (t == 14)) begin n_fail++; $display("FAIL s0_frame_done t=%0d got %b exp %b", t, frame_done_z, (t == 14)); end
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         rd_sel_z = 3'(i); #1;
         e = (i < 7) ? 8'(8'h50 + i) : 8'h00;
         n_tests++; if (rd_data_z !== e) begin n_fail++; $display("FAIL s0_rd sel=%0d got %h exp %h", i, rd_data_z, e); end
      end
   endtask

   initial begin
      test_reset();
      test_snap_frame();
      test_continuous();
      test_enable_drop();
      test_reset_mid_frame();
      test_change();
      test_settle0();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
